// File: rtl/wb_bram_pkg.sv
// -----------------------------------------------------------------------------
// wb_bram_pkg
// Shared types and constants for the Wishbone-to-BRAM controller.
//   state_e        : controller FSM states
//   BASE_ADDR_DEF  : default region base address
//   ADDR_MASK_DEF  : default region decode mask
//   DELAYS_MAX     : largest wait-state count the 8-bit counter can hold
//   CNT_W          : wait-state counter width
// -----------------------------------------------------------------------------
package wb_bram_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    ACCESS  = 3'd2,
    CAPTURE = 3'd3,
    ACK     = 3'd4
  } state_e;

  localparam logic [31:0] BASE_ADDR_DEF = 32'h3800_0000;
  localparam logic [31:0] ADDR_MASK_DEF = 32'hFFC0_0000;
  localparam int unsigned DELAYS_MAX    = 255;
  localparam int unsigned CNT_W         = 8;

endpackage

// File: rtl/wb_bram_ctrl_delay_counter.sv
// -----------------------------------------------------------------------------
// delay_counter
// Down-counter used to insert wait states before a BRAM access.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_load      : load i_load_val (has priority over i_en)
//   i_load_val  : wait-state count to load
//   i_en        : decrement while non-zero
//   o_done      : high while the count equals 1 (last wait cycle)
// -----------------------------------------------------------------------------
module delay_counter
  import wb_bram_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its inputs, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/wb_bram_ctrl.sv
// -----------------------------------------------------------------------------
// wb_bram_ctrl
// Wishbone classic slave bridging user-project bus cycles to a single-port
// BRAM, with a fixed number of wait states before each access.
//   Parameters : BASE_ADDR / ADDR_MASK region decode, AW word-index width,
//                DELAYS wait states (0..DELAYS_MAX)
//   Bus side   : wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i,
//                wbs_dat_i -> wbs_ack_o (1-cycle pulse), wbs_dat_o
//   BRAM side  : EN0, WE0, A0, Di0 (all registered, live only in ACCESS),
//                Do0 (registered BRAM read data, valid in CAPTURE)
// -----------------------------------------------------------------------------
module wb_bram_ctrl
  import wb_bram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter logic [31:0] ADDR_MASK = ADDR_MASK_DEF,
  parameter int unsigned AW        = 12,
  parameter int unsigned DELAYS    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        EN0,
  output logic [3:0]  WE0,
  output logic [31:0] A0,
  output logic [31:0] Di0,
  input  logic [31:0] Do0
);

  localparam logic [CNT_W-1:0] LP_DELAYS = CNT_W'(DELAYS);

  state_e        r_state, w_next;
  logic [AW-1:0] r_idx;
  logic          r_we;
  logic [3:0]    r_sel;
  logic [31:0]   r_dat;

  logic          r_ack;
  logic [31:0]   r_dat_o;
  logic          r_en0;
  logic [3:0]    r_we0;
  logic [31:0]   r_a0;
  logic [31:0]   r_di0;

  logic          w_hit, w_req, w_accept, w_cnt_done;
  logic [AW-1:0] w_src_idx;
  logic          w_src_we;
  logic [3:0]    w_src_sel;
  logic [31:0]   w_src_dat;
  logic          w_en0_d, w_ack_d;
  logic [3:0]    w_we0_d;
  logic [31:0]   w_a0_d, w_di0_d;

  assign w_hit    = ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  assign w_req    = wbs_cyc_i & wbs_stb_i & w_hit;
  assign w_accept = (r_state == IDLE) & w_req;

  delay_counter u_delay_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept),
    .i_load_val (LP_DELAYS),
    .i_en       (r_state == WAIT),
    .o_done     (w_cnt_done)
  );

  // State register, captured request and registered bus/BRAM outputs.
  // NOTE: every register here is reset, so an interrupted transaction leaves
  // no stale index/data behind and all outputs read 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_dat   <= '0;
      r_ack   <= 1'b0;
      r_dat_o <= '0;
      r_en0   <= 1'b0;
      r_we0   <= '0;
      r_a0    <= '0;
      r_di0   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_idx <= wbs_adr_i[AW+1:2];
        r_we  <= wbs_we_i;
        r_sel <= wbs_sel_i;
        r_dat <= wbs_dat_i;
      end
      r_ack <= w_ack_d;
      r_en0 <= w_en0_d;
      r_we0 <= w_we0_d;
      r_a0  <= w_a0_d;
      r_di0 <= w_di0_d;
      if (r_state == CAPTURE) begin
        r_dat_o <= Do0;
      end
    end
  end

  // Next-state logic. Dropping cyc in WAIT abandons the cycle before the
  // BRAM is touched.
  // NOTE: each always_comb assigns a default first so no path holds a value,
  // which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_req) w_next = (LP_DELAYS == '0) ? ACCESS : WAIT;
      WAIT:    if (!wbs_cyc_i) w_next = IDLE;
               else if (w_cnt_done) w_next = ACCESS;
      ACCESS:  w_next = r_we ? ACK : CAPTURE;
      CAPTURE: w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output decode: values the output registers take on the coming edge.
  // Outputs are registered, so they are decoded from the next state; when
  // leaving IDLE the request has not been latched yet, so the bus is used.
  always_comb begin
    w_src_idx = r_idx;
    w_src_we  = r_we;
    w_src_sel = r_sel;
    w_src_dat = r_dat;
    if (r_state == IDLE) begin
      w_src_idx = wbs_adr_i[AW+1:2];
      w_src_we  = wbs_we_i;
      w_src_sel = wbs_sel_i;
      w_src_dat = wbs_dat_i;
    end

    w_en0_d = 1'b0;
    w_we0_d = '0;
    w_a0_d  = '0;
    w_di0_d = '0;
    if (w_next == ACCESS) begin
      w_en0_d = 1'b1;
      w_we0_d = w_src_we ? w_src_sel : 4'b0000;
      w_a0_d  = 32'(w_src_idx);
      w_di0_d = w_src_dat;
    end

    // A master that has already dropped cyc gets no ack.
    w_ack_d = (w_next == ACK) & wbs_cyc_i;
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat_o;
  assign EN0       = r_en0;
  assign WE0       = r_we0;
  assign A0        = r_a0;
  assign Di0       = r_di0;

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wb_bram_ctrl
// Directed bench for wb_bram_ctrl. Two instances share one bus driver:
// u_dut0 with DELAYS=10 and u_dut1 with DELAYS=0; dsel routes cyc to one of
// them. Each instance has its own behavioural BRAM (registered read data,
// zero when not enabled, per-byte writes).
// -----------------------------------------------------------------------------
module tb_wb_bram_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        cyc, stb, we, dsel;
  logic [3:0]  sel;
  logic [31:0] adr, dat;

  logic        cyc_v [2];
  logic        ack_v [2];
  logic [31:0] dato_v[2];
  logic        en_v  [2];
  logic [3:0]  we0_v [2];
  logic [31:0] a0_v  [2];
  logic [31:0] di0_v [2];
  logic [31:0] do0_v [2];

  assign cyc_v[0] = cyc & ~dsel;
  assign cyc_v[1] = cyc &  dsel;

  wb_bram_ctrl #(.DELAYS(10)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .wbs_cyc_i(cyc_v[0]), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat),
    .wbs_ack_o(ack_v[0]), .wbs_dat_o(dato_v[0]),
    .EN0(en_v[0]), .WE0(we0_v[0]), .A0(a0_v[0]), .Di0(di0_v[0]), .Do0(do0_v[0])
  );

  wb_bram_ctrl #(.DELAYS(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .wbs_cyc_i(cyc_v[1]), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat),
    .wbs_ack_o(ack_v[1]), .wbs_dat_o(dato_v[1]),
    .EN0(en_v[1]), .WE0(we0_v[1]), .A0(a0_v[1]), .Di0(di0_v[1]), .Do0(do0_v[1])
  );

  // Behavioural BRAMs.
  logic [31:0] mem0 [4096] = '{default: 32'h0};
  logic [31:0] mem1 [4096] = '{default: 32'h0};
  int en_total0 = 0;
  int en_total1 = 0;

  always @(posedge clk) begin
    if (en_v[0]) begin
      for (int b = 0; b < 4; b++)
        if (we0_v[0][b]) mem0[a0_v[0][11:0]][8*b +: 8] <= di0_v[0][8*b +: 8];
      do0_v[0]  <= mem0[a0_v[0][11:0]];
      en_total0 <= en_total0 + 1;
    end else begin
      do0_v[0] <= 32'h0;
    end
  end

  always @(posedge clk) begin
    if (en_v[1]) begin
      for (int b = 0; b < 4; b++)
        if (we0_v[1][b]) mem1[a0_v[1][11:0]][8*b +: 8] <= di0_v[1][8*b +: 8];
      do0_v[1]  <= mem1[a0_v[1][11:0]];
      en_total1 <= en_total1 + 1;
    end else begin
      do0_v[1] <= 32'h0;
    end
  end

  // Outputs of the currently selected instance.
  logic        ack_m, en_m;
  logic [31:0] dato_m, a0_m, di0_m;
  logic [3:0]  we0_m;
  assign ack_m  = ack_v[dsel];
  assign en_m   = en_v[dsel];
  assign dato_m = dato_v[dsel];
  assign a0_m   = a0_v[dsel];
  assign di0_m  = di0_v[dsel];
  assign we0_m  = we0_v[dsel];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One bus transaction. Call mid-cycle (just after an edge); that cycle is
  // cycle 0. Cycle numbers of the first EN0 and of ack are reported (-1 when
  // absent); BRAM outputs are latched at the first EN0 cycle. side_viol counts
  // cycles where WE0/A0/Di0 are non-zero without EN0.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input int abort_at, input int limit,
                      output int ack_cyc, output int en_cyc, output int en_cnt,
                      output logic [31:0] a0_s, output logic [3:0] we0_s,
                      output logic [31:0] di0_s, output logic [31:0] rd,
                      output int side_viol);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d;
    ack_cyc = -1; en_cyc = -1; en_cnt = 0; side_viol = 0;
    a0_s = '0; we0_s = '0; di0_s = '0; rd = '0;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk); #1;
      if (k == abort_at) begin cyc = 1'b0; stb = 1'b0; end
      if (en_m) begin
        en_cnt++;
        if (en_cyc < 0) begin en_cyc = k; a0_s = a0_m; we0_s = we0_m; di0_s = di0_m; end
      end else if ((we0_m != 4'h0) || (a0_m != 32'h0) || (di0_m != 32'h0)) begin
        side_viol++;
      end
      if (ack_m) begin ack_cyc = k; rd = dato_m; break; end
    end
    cyc = 1'b0; stb = 1'b0;
  endtask

  int          ac, ec, enn, sv, e0, rel_ack;
  logic [31:0] a0s, di0s, rdv;
  logic [3:0]  we0s;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat = 0; dsel = 0;
    rst_n = 1'b1;

    // Reset, then idle.
    #1 rst_n = 1'b0;
    #1;
    check("rst_ack",  32'(ack_v[0]), 32'h0);
    check("rst_dato", dato_v[0], 32'h0);
    check("rst_en0",  32'(en_v[0] | en_v[1]), 32'h0);
    check("rst_bram", a0_v[0] | di0_v[0] | 32'(we0_v[0]), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    e0 = en_total0 + en_total1;
    repeat (20) @(posedge clk);
    #1 check("idle_no_en", en_total0 + en_total1, e0);

    // DELAYS=10 full-word write.
    xfer(1'b1, 32'h3800_0010, 4'hF, 32'hDEAD_BEEF, 0, 400, ac, ec, enn, a0s, we0s, di0s, rdv, sv);
    check("wr_ack_cycle", ac, 12);
    check("wr_en_cycle",  ec, 11);
    check("wr_en_pulses", enn, 1);
    check("wr_a0",  a0s, 32'h4);
    check("wr_we0", 32'(we0s), 32'hF);
    check("wr_di0", di0s, 32'hDEAD_BEEF);
    check("wr_idle_outputs_zero", sv, 0);
    @(posedge clk); #1;
    check("ack_one_cycle", 32'(ack_m), 32'h0);
    check("wr_bram_word", mem0[4], 32'hDEAD_BEEF);

    // Read it back.
    xfer(1'b0, 32'h3800_0010, 4'hF, 32'h0, 0, 400, ac, ec, enn, a0s, we0s, di0s, rdv, sv);
    check("rd_ack_cycle", ac, 13);
    check("rd_en_cycle",  ec, 11);
    check("rd_we0_zero",  32'(we0s), 32'h0);
    check("rd_data",      rdv, 32'hDEAD_BEEF);

    // Byte-lane write then read.
    @(posedge clk); #1;
    xfer(1'b1, 32'h3800_0010, 4'b0001, 32'h0000_00AA, 0, 400, ac, ec, enn, a0s, we0s, di0s, rdv, sv);
    check("bw_ack_cycle", ac, 12);
    check("bw_we0", 32'(we0s), 32'h1);
    check("bw_dato_unchanged", dato_m, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    xfer(1'b0, 32'h3800_0010, 4'hF, 32'h0, 0, 400, ac, ec, enn, a0s, we0s, di0s, rdv, sv);
    check("bw_rd_data", rdv, 32'hDEAD_BEAA);

    // Out-of-region request.
    @(posedge clk); #1;
    xfer(1'b1, 32'h3000_0000, 4'hF, 32'h1234_5678, 0, 300, ac, ec, enn, a0s, we0s, di0s, rdv, sv);
    check("oor_no_ack", ac, -1);
    check("oor_no_en",  enn, 0);

    // Abort in WAIT.
    @(posedge clk); #1;
    xfer(1'b1, 32'h3800_0010, 4'hF, 32'h1234_5678, 5, 30, ac, ec, enn, a0s, we0s, di0s, rdv, sv);
    check("abort_no_ack", ac, -1);
    check("abort_no_en",  enn, 0);
    check("abort_bram_kept", mem0[4], 32'hDEAD_BEAA);
    xfer(1'b0, 32'h3800_0010, 4'hF, 32'h0, 0, 400, ac, ec, enn, a0s, we0s, di0s, rdv, sv);
    check("post_abort_ack_cycle", ac, 13);
    check("post_abort_rd_data", rdv, 32'hDEAD_BEAA);

    // DELAYS=0 back-to-back: read driven as soon as write ack is seen.
    dsel = 1'b1;
    @(posedge clk); #1;
    xfer(1'b1, 32'h3800_0020, 4'hF, 32'hCAFE_F00D, 0, 400, ac, ec, enn, a0s, we0s, di0s, rdv, sv);
    check("d0_wr_ack_cycle", ac, 2);
    check("d0_wr_en_cycle",  ec, 1);
    check("d0_wr_a0", a0s, 32'h8);
    rel_ack = ac;
    xfer(1'b0, 32'h3800_0020, 4'hF, 32'h0, 0, 400, ac, ec, enn, a0s, we0s, di0s, rdv, sv);
    check("d0_rd_ack_cycle", rel_ack + ac, 6);
    check("d0_rd_en_cycle",  rel_ack + ec, 4);
    check("d0_rd_data", rdv, 32'hCAFE_F00D);

    // Top word index, and an in-region alias above the BRAM index bits.
    @(posedge clk); #1;
    xfer(1'b1, 32'h3800_3FFC, 4'hF, 32'h1111_1111, 0, 400, ac, ec, enn, a0s, we0s, di0s, rdv, sv);
    check("top_idx_a0", a0s, 32'h0000_0FFF);
    check("top_idx_dato_unchanged", dato_m, 32'hCAFE_F00D);
    @(posedge clk); #1;
    xfer(1'b0, 32'h3830_0020, 4'hF, 32'h0, 0, 400, ac, ec, enn, a0s, we0s, di0s, rdv, sv);
    check("alias_ack_cycle", ac, 3);
    check("alias_rd_data", rdv, 32'hCAFE_F00D);

    // Asynchronous reset during a DELAYS=10 write still in WAIT.
    dsel = 1'b0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3800_0040; sel = 4'hF; dat = 32'h55AA_55AA;
    e0 = en_total0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_dato0", dato_v[0], 32'h0);
    check("midrst_dato1", dato_v[1], 32'h0);
    check("midrst_ack_en", 32'(ack_v[0] | en_v[0] | ack_v[1] | en_v[1]), 32'h0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_en", en_total0, e0);
    check("midrst_bram_untouched", mem0[16], 32'h0);
    xfer(1'b0, 32'h3800_0010, 4'hF, 32'h0, 0, 400, ac, ec, enn, a0s, we0s, di0s, rdv, sv);
    check("post_rst_ack_cycle", ac, 13);
    check("post_rst_rd_data", rdv, 32'hDEAD_BEAA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_bram_ctrl.md
# wb_bram_ctrl

Wishbone classic slave that turns user-project bus cycles into single-port accesses on the user BRAM (32-bit data, per-byte write enables, registered read data that is forced to zero when not enabled). It sits between the Caravel user Wishbone bus and the BRAM's EN0/WE0/A0/Di0/Do0 port. It adds a programmable wait-state count that models slow external memory for firmware timing studies.

## Interface

- BASE_ADDR, 32'h3800_0000, region base; hit when (wbs_adr_i & ADDR_MASK) == BASE_ADDR
- ADDR_MASK, 32'hFFC0_0000, region decode mask
- AW, 12, BRAM word-index width
- DELAYS, 10, wait states inserted before each BRAM access; legal range 0..255

- clk  in  1  the single clock
- rst_n  in  1  reset, asynchronous, active-low
- wbs_cyc_i  in  1  bus cycle
- wbs_stb_i  in  1  strobe
- wbs_we_i  in  1  1 = write
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge, one-cycle pulse
- wbs_dat_o  out  32  read data, valid while ack is high
- EN0  out  1  BRAM enable
- WE0  out  4  BRAM byte write enables
- A0  out  32  BRAM word index, zero-extended from AW bits
- Di0  out  32  BRAM write data
- Do0  in  32  BRAM registered read data

## Operation

- A request is cyc & stb & hit, sampled in IDLE. On acceptance, the block latches adr[AW+1:2], we, sel and dat_i. Later changes on the bus are ignored.
- A non-hit request is ignored. There is no ack, and the block stays in IDLE.
- States:
  - IDLE: on acceptance, go to WAIT with counter = DELAYS. If DELAYS == 0, go directly to ACCESS.
  - WAIT: decrement the counter each cycle. When the counter equals 1, go to ACCESS. If cyc is low, go to IDLE; no BRAM access occurs and no ack is issued.
  - ACCESS: for exactly one cycle, drive EN0=1, A0=index, Di0=data, WE0 = sel if we, else 4'b0. Writes then go to ACK; reads go to CAPTURE.
  - CAPTURE: Do0 is valid during this cycle. Register Do0 into wbs_dat_o at the closing edge, then go to ACK.
  - ACK: drive wbs_ack_o=1 for one cycle, then go to IDLE. If cyc is low on entry to ACK, suppress ack and go to IDLE. A write already committed in ACCESS is not undone.
- EN0, WE0, A0 and Di0 are 0 in every state except ACCESS.
- wbs_dat_o holds its last read value until the next CAPTURE. It is unchanged by writes.
- No pipelining: one outstanding transaction at a time. A request present during ACK is not accepted until IDLE.
- Reset mid-operation: the next cycle starts in IDLE with all outputs 0. A write whose ACCESS cycle had not yet occurred never reaches the BRAM.

## Timing

- All outputs are registered. Reset values: wbs_ack_o=0, wbs_dat_o=0, EN0=0, WE0=0, A0=0, Di0=0; state IDLE; counter 0.
- Cycle 0 is the first cycle in which the request is visible. The block accepts it at the end of cycle 0.
- ACCESS occupies cycle DELAYS+1.
- Ack is high in cycle DELAYS+2 for writes and DELAYS+3 for reads.
- With DELAYS=0: write ack in cycle 2, read ack in cycle 3.
- The earliest acceptance of the next request is the cycle after ACK.
- The counter is 8 bits wide. It never underflows, because WAIT is entered only when DELAYS ≥ 1.

## Structure

- Shared package wb_bram_pkg contains:
  - the state enum (IDLE, WAIT, ACCESS, CAPTURE, ACK);
  - default BASE_ADDR/ADDR_MASK constants;
  - the DELAYS_MAX=255 constant.
- The wait-state counter is a natural sub-module: delay_counter (load, enable, done flag).
- The FSM and the bus/BRAM registers stay in wb_bram_ctrl.

## Test plan

- Reset then idle: hold rst_n=0 mid-cycle -> all outputs 0 immediately (asynchronous). With no request after release, EN0 stays 0.
- Full-word write, DELAYS=10: write 0xDEADBEEF to 0x3800_0010 with sel=4'hF -> in cycle 11, EN0=1, A0=4, WE0=4'hF; ack in cycle 12. A read of the same address then returns 0xDEADBEEF with ack in cycle 13.
- Byte-lane write: over 0xDEADBEEF, write 0x000000AA with sel=4'b0001 -> a later read returns 0xDEADBEAA.
- Out-of-region request: wbs_adr_i=0x3000_0000 -> no ack for 300 cycles, EN0 never asserted.
- Abort in WAIT: drop cyc in cycle 5 of a write with DELAYS=10 -> no EN0 pulse, no ack, BRAM contents unchanged. A next request is accepted normally.
- Back-to-back with DELAYS=0: write then read issued on consecutive acks -> write ack in cycle 2. The read is accepted in cycle 3 and acked in cycle 6 with the written data.
